id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand selection; sits directly upstream of the EX-stage ALUs (shift ALU, arithmetic/logic ALU, branch compare).
- Captures decoded ID fields each cycle and presents them to EX as registered values.
- Drives forwarded, selected operands op1/op2 plus raw opcode/func3/func7/imm, so the shift ALU takes its inputs unmodified from this block.
- Handles pipeline stall (hold), flush (bubble insertion) and the x0 write-suppression rule.

---
 rtl/id_ex_stage.sv | 105 ++++++++++
 tb/tb_id_ex_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand select.
// Define ID_EX_FORWARD_EN to enable the MEM/WB forwarding muxes on rs1/rs2.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_func3,
  input  logic [6:0]      id_func7,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_reg_write,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_func3,
  output logic [6:0]      ex_func7,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_write,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_store_data
);
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  logic            r_valid, r_reg_write;
  logic [XLEN-1:0] r_pc, r_imm, r_rs1_data, r_rs2_data;
  logic [6:0]      r_opcode, r_func7;
  logic [2:0]      r_func3;
  logic [4:0]      r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [XLEN-1:0] w_fwd_a, w_fwd_b;
  // A bubble is the same whether it comes from reset, flush or an invalid ID slot.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !id_valid)) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_pc        <= RESET_PC;
      r_imm       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_opcode    <= '0;
      r_func3     <= '0;
      r_func7     <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
    end else if (!stall) begin
      r_valid     <= 1'b1;
      r_reg_write <= id_reg_write && (id_rd_addr != 5'd0);
      r_pc        <= id_pc;
      r_imm       <= id_imm;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_opcode    <= id_opcode;
      r_func3     <= id_func3;
      r_func7     <= id_func7;
      r_rs1_addr  <= id_rs1_addr;
      r_rs2_addr  <= id_rs2_addr;
      r_rd_addr   <= id_rd_addr;
    end
  end
`ifdef ID_EX_FORWARD_EN
  assign w_fwd_a = fwd_a_sel == 2'b01 ? mem_fwd_data : fwd_a_sel == 2'b10 ? wb_fwd_data : r_rs1_data;
  assign w_fwd_b = fwd_b_sel == 2'b01 ? mem_fwd_data : fwd_b_sel == 2'b10 ? wb_fwd_data : r_rs2_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data};
  assign w_fwd_a = r_rs1_data;
  assign w_fwd_b = r_rs2_data;
`endif
  assign ex_op1 = (r_opcode == OP_AUIPC || r_opcode == OP_JAL) ? r_pc :
                  r_opcode == OP_LUI ? '0 : w_fwd_a;
  assign ex_op2 = (r_opcode == OP_R || r_opcode == OP_B) ? w_fwd_b : r_imm;
  assign ex_store_data = w_fwd_b;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_pc         = r_pc;
  assign ex_imm        = r_imm;
  assign ex_opcode     = r_opcode;
  assign ex_func3      = r_func3;
  assign ex_func7      = r_func7;
  assign ex_rs1_addr   = r_rs1_addr;
  assign ex_rs2_addr   = r_rs2_addr;
  assign ex_rd_addr    = r_rd_addr;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
  localparam logic [31:0] RPC = 32'h0000_0040;
  logic        clk = 1'b0, rst, stall, flush, id_valid, id_reg_write;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data, mem_fwd_data, wb_fwd_data;
  logic [6:0]  id_opcode, id_func7;
  logic [2:0]  id_func3;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        ex_valid, ex_reg_write;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2, ex_store_data;
  logic [6:0]  ex_opcode, ex_func7;
  logic [2:0]  ex_func3;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  typedef struct {
    logic        v, rw, ck1;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, op1, op2;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  id_ex_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_func3(id_func3), .id_func7(id_func7),
    .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_opcode(ex_opcode),
    .ex_func3(ex_func3), .ex_func7(ex_func7), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rw);
    id_valid = v; id_pc = pc; id_opcode = op; id_func3 = f3; id_func7 = 7'h20; id_imm = imm;
    id_rs1_data = rs1; id_rs2_data = rs2; id_rs1_addr = 5'd1; id_rs2_addr = 5'd2;
    id_rd_addr = rd; id_reg_write = rw;
  endtask
  task automatic expect_e(input logic v, input logic rw, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2, input logic ck1);
    exp_t e;
    e.v = v; e.rw = rw; e.op = op; e.f3 = f3; e.pc = pc; e.op1 = op1; e.op2 = op2; e.ck1 = ck1;
    sb.push_back(e);
  endtask
  task automatic tick_and_compare(input string tag);
    exp_t e;
    @(posedge clk); #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.v});
      check({tag, ".reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
      check({tag, ".opcode"}, {25'd0, ex_opcode}, {25'd0, e.op});
      check({tag, ".func3"}, {29'd0, ex_func3}, {29'd0, e.f3});
      check({tag, ".pc"}, ex_pc, e.pc);
      check({tag, ".op2"}, ex_op2, e.op2);
      if (e.ck1) check({tag, ".op1"}, ex_op1, e.op1);
    end
  endtask
  initial begin
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; mem_fwd_data = 32'd3; wb_fwd_data = 32'd7;
    drive(1'b1, 32'h1234, 7'b0110011, 3'd7, 32'h55, 32'h66, 32'h77, 5'd9, 1'b1);
    @(posedge clk);
    expect_e(1'b0, 1'b0, 7'd0, 3'd0, RPC, 32'd0, 32'd0, 1'b1);
    tick_and_compare("reset");
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h10, 7'b0010011, 3'b101, 32'h403, 32'h8000_0000, 32'h1234, 5'd5, 1'b1);
    expect_e(1'b1, 1'b1, 7'b0010011, 3'b101, 32'h10, 32'h8000_0000, 32'h403, 1'b1);
    tick_and_compare("srai");
    drive(1'b1, 32'h14, 7'b0110011, 3'd0, 32'h0, 32'd9, 32'd5, 5'd6, 1'b1);
    expect_e(1'b1, 1'b1, 7'b0110011, 3'd0, 32'h14, 32'd9, 32'd5, 1'b1);
    tick_and_compare("add");
    fwd_b_sel = 2'b01; fwd_a_sel = 2'b10; #1;
`ifdef ID_EX_FORWARD_EN
    check("fwd_b_mem", ex_op2, 32'd3);
    check("fwd_a_wb", ex_op1, 32'd7);
    check("store_mem", ex_store_data, 32'd3);
`else
    check("fwd_b_mem", ex_op2, 32'd5);
    check("fwd_a_wb", ex_op1, 32'd9);
    check("store_mem", ex_store_data, 32'd5);
`endif
    fwd_b_sel = 2'b10; #1;
`ifdef ID_EX_FORWARD_EN
    check("fwd_b_wb", ex_op2, 32'd7);
`else
    check("fwd_b_wb", ex_op2, 32'd5);
`endif
    fwd_b_sel = 2'b11; fwd_a_sel = 2'b11; #1;
    check("fwd_b_11", ex_op2, 32'd5);
    check("fwd_a_11", ex_op1, 32'd9);
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 32'h900 + i, 7'b0110111, 3'd3, 32'hABC, 32'd1, 32'd2, 5'd0, 1'b0);
      expect_e(1'b1, 1'b1, 7'b0110011, 3'd0, 32'h14, 32'd9, 32'd5, 1'b1);
      tick_and_compare("stall");
    end
    flush = 1'b1;
    expect_e(1'b0, 1'b0, 7'd0, 3'd0, RPC, 32'd0, 32'd0, 1'b0);
    tick_and_compare("flush_stall");
    flush = 1'b0; stall = 1'b0;
    drive(1'b1, 32'h20, 7'b0110011, 3'd0, 32'h0, 32'd4, 32'd8, 5'd0, 1'b1);
    expect_e(1'b1, 1'b0, 7'b0110011, 3'd0, 32'h20, 32'd4, 32'd8, 1'b1);
    tick_and_compare("x0_write");
    drive(1'b0, 32'h24, 7'b0110011, 3'd2, 32'h44, 32'd4, 32'd8, 5'd3, 1'b1);
    expect_e(1'b0, 1'b0, 7'd0, 3'd0, RPC, 32'd0, 32'd0, 1'b0);
    tick_and_compare("bubble");
    drive(1'b1, 32'h100, 7'b0010111, 3'd0, 32'h1000, 32'hDEAD, 32'h0, 5'd7, 1'b1);
    expect_e(1'b1, 1'b1, 7'b0010111, 3'd0, 32'h100, 32'h100, 32'h1000, 1'b1);
    tick_and_compare("auipc");
    drive(1'b1, 32'h104, 7'b0110111, 3'd0, 32'h1234_5000, 32'hDEAD, 32'h0, 5'd8, 1'b1);
    expect_e(1'b1, 1'b1, 7'b0110111, 3'd0, 32'h104, 32'd0, 32'h1234_5000, 1'b1);
    tick_and_compare("lui");
    drive(1'b1, 32'h200, 7'b1101111, 3'd0, 32'h8, 32'hBEEF, 32'h0, 5'd1, 1'b1);
    expect_e(1'b1, 1'b1, 7'b1101111, 3'd0, 32'h200, 32'h200, 32'h8, 1'b1);
    tick_and_compare("jal");
    drive(1'b1, 32'h300, 7'b1100011, 3'd1, 32'h10, 32'd1, 32'd2, 5'd0, 1'b0);
    expect_e(1'b1, 1'b0, 7'b1100011, 3'd1, 32'h300, 32'd1, 32'd2, 1'b1);
    tick_and_compare("branch");
    check("store_data", ex_store_data, 32'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
